// File: rtl/wasm_operand_stack_if.sv
// Operand-stack port bundle: op/din from the execute stage, stack state back to it.
// Optional high-water-mark output is present when WASM_STACK_HWM_EN is defined.
interface wasm_operand_stack_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 5
);
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic [2:0]       trap;
`ifdef WASM_STACK_HWM_EN
    logic [CNT_W-1:0] hwm;
`endif

    modport master (
        output op, din,
        input  top, next, count, empty, full, trap
`ifdef WASM_STACK_HWM_EN
        , input hwm
`endif
    );

    modport slave (
        input  op, din,
        output top, next, count, empty, full, trap
`ifdef WASM_STACK_HWM_EN
        , output hwm
`endif
    );
endinterface

// File: rtl/wasm_operand_stack.sv
// WebAssembly operand stack: TOS/NOS in registers, deeper entries in a spill array.
// Define WASM_STACK_HWM_EN to add the hwm (high-water mark) output.
module wasm_operand_stack #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input logic                 clk,
    input logic                 reset,
    wasm_operand_stack_if.slave bus
);
    localparam int unsigned MEM_D = (DEPTH > 2) ? DEPTH - 2 : 1;
    localparam int unsigned AW    = (MEM_D > 1) ? $clog2(MEM_D) : 1;

    localparam logic [2:0] OpNop     = 3'd0;
    localparam logic [2:0] OpPush    = 3'd1;
    localparam logic [2:0] OpPop     = 3'd2;
    localparam logic [2:0] OpReplace = 3'd3;
    localparam logic [2:0] OpBinop   = 3'd4;
    localparam logic [2:0] OpDup     = 3'd5;

    localparam logic [2:0] TrapNone      = 3'd0;
    localparam logic [2:0] TrapOverflow  = 3'd1;
    localparam logic [2:0] TrapUnderflow = 3'd2;
    localparam logic [2:0] TrapInvalid   = 3'd3;

    logic [WIDTH-1:0] top_q, top_d, next_q, next_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       trap_q, trap_d;
    logic [WIDTH-1:0] mem [MEM_D];
    logic             spill_we;
    logic [AW-1:0]    rd_idx, wr_idx;
    logic [WIDTH-1:0] refill;
    logic             is_empty, is_full, ge2, ge3;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign ge2      = (count_q >= CNT_W'(2));
    assign ge3      = (count_q >= CNT_W'(3));
    assign rd_idx   = AW'(count_q - CNT_W'(3));
    assign wr_idx   = AW'(count_q - CNT_W'(2));
    // Entry that becomes NOS when the stack shrinks; a vacated NOS reads zero.
    assign refill   = ge3 ? mem[rd_idx] : '0;

    always_comb begin
        top_d    = top_q;
        next_d   = next_q;
        count_d  = count_q;
        trap_d   = trap_q;
        spill_we = 1'b0;
        if (trap_q == TrapNone) begin
            case (bus.op)
                OpNop: ;
                OpPush: begin
                    if (is_full) begin
                        trap_d = TrapOverflow;
                    end else begin
                        next_d   = top_q;
                        top_d    = bus.din;
                        count_d  = count_q + CNT_W'(1);
                        spill_we = ge2;
                    end
                end
                OpPop: begin
                    if (is_empty) begin
                        trap_d = TrapUnderflow;
                    end else begin
                        top_d   = next_q;
                        next_d  = refill;
                        count_d = count_q - CNT_W'(1);
                    end
                end
                OpReplace: begin
                    if (is_empty) trap_d = TrapUnderflow;
                    else          top_d  = bus.din;
                end
                OpBinop: begin
                    if (!ge2) begin
                        trap_d = TrapUnderflow;
                    end else begin
                        top_d   = bus.din;
                        next_d  = refill;
                        count_d = count_q - CNT_W'(1);
                    end
                end
                OpDup: begin
                    if (is_empty) begin
                        trap_d = TrapUnderflow;
                    end else if (is_full) begin
                        trap_d = TrapOverflow;
                    end else begin
                        next_d   = top_q;
                        count_d  = count_q + CNT_W'(1);
                        spill_we = ge2;
                    end
                end
                default: trap_d = TrapInvalid;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q   <= '0;
            next_q  <= '0;
            count_q <= '0;
            trap_q  <= TrapNone;
        end else begin
            top_q   <= top_d;
            next_q  <= next_d;
            count_q <= count_d;
            trap_q  <= trap_d;
        end
    end

    // Spill contents are don't-care after reset, so the array is not reset.
    always_ff @(posedge clk) begin
        if (spill_we) mem[wr_idx] <= next_q;
    end

    assign bus.top   = top_q;
    assign bus.next  = next_q;
    assign bus.count = count_q;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.trap  = trap_q;

`ifdef WASM_STACK_HWM_EN
    logic [CNT_W-1:0] hwm_q;

    // Faulting ops leave count unchanged, so gating on trap_q alone is enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hwm_q <= '0;
        end else if (trap_q == TrapNone && count_d > hwm_q) begin
            hwm_q <= count_d;
        end
    end

    assign bus.hwm = hwm_q;
`endif
endmodule

// File: tb/tb_wasm_operand_stack.sv
// Self-checking bench for wasm_operand_stack: directed vector table, corner sequences,
// and random ops against a queue-based reference model.
module tb_wasm_operand_stack;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    wasm_operand_stack_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    wasm_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic [2:0]  op;
        logic [63:0] din;
        logic [63:0] e_top;
        logic [63:0] e_next;
        int          e_cnt;
        logic [2:0]  e_trap;
    } vec_t;

    vec_t vecs[32];
    int   nv = 0;

    // Reference model: the stack as a queue, back = TOS.
    logic [63:0] mq[$];
    logic [2:0]  mtrap;
    int          mhwm;

    task automatic add(input logic r, input logic [2:0] op, input logic [63:0] din,
                       input logic [63:0] et, input logic [63:0] en, input int ec,
                       input logic [2:0] etr);
        vecs[nv] = '{r, op, din, et, en, ec, etr};
        nv++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag, input logic [63:0] et, input logic [63:0] en,
                             input int ec, input logic [2:0] etr);
        chk({tag, ".top"}, bus.top, et);
        chk({tag, ".next"}, bus.next, en);
        chk({tag, ".count"}, 64'(bus.count), 64'(ec));
        chk({tag, ".empty"}, 64'(bus.empty), 64'(ec == 0));
        chk({tag, ".full"}, 64'(bus.full), 64'(ec == DEPTH));
        chk({tag, ".trap"}, 64'(bus.trap), 64'(etr));
    endtask

    task automatic do_reset();
        bus.op = 3'd0;
        reset  = 1'b1;
        #2;
        reset  = 1'b0;
        mq.delete();
        mtrap = 3'd0;
        mhwm  = 0;
    endtask

    task automatic apply(input logic [2:0] op, input logic [63:0] din);
        bus.op  = op;
        bus.din = din;
        @(posedge clk);
        #1;
        bus.op = 3'd0;
    endtask

    function automatic logic [63:0] m_top();
        return (mq.size() >= 1) ? mq[mq.size()-1] : 64'd0;
    endfunction

    function automatic logic [63:0] m_next();
        return (mq.size() >= 2) ? mq[mq.size()-2] : 64'd0;
    endfunction

    task automatic model_op(input logic [2:0] op, input logic [63:0] din);
        int n;
        n = mq.size();
        if (mtrap != 3'd0) return;
        case (op)
            3'd0: ;
            3'd1: if (n == DEPTH) mtrap = 3'd1; else mq.push_back(din);
            3'd2: if (n == 0) mtrap = 3'd2; else void'(mq.pop_back());
            3'd3: if (n == 0) mtrap = 3'd2; else mq[n-1] = din;
            3'd4: if (n < 2) mtrap = 3'd2;
                  else begin void'(mq.pop_back()); mq[n-2] = din; end
            3'd5: if (n == 0) mtrap = 3'd2;
                  else if (n == DEPTH) mtrap = 3'd1;
                  else mq.push_back(mq[n-1]);
            default: mtrap = 3'd3;
        endcase
        if (mq.size() > mhwm) mhwm = mq.size();
    endtask

    initial begin
        bus.op  = 3'd0;
        bus.din = '0;
        reset   = 1'b1;
        mtrap   = 3'd0;
        mhwm    = 0;
        #2;
        chk_state("reset", 64'd0, 64'd0, 0, 3'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed table
        add(1, 3'd1, 64'h11, 64'h11, 64'h00, 1, 3'd0);
        add(0, 3'd1, 64'h22, 64'h22, 64'h11, 2, 3'd0);
        add(0, 3'd1, 64'h33, 64'h33, 64'h22, 3, 3'd0);
        add(0, 3'd4, 64'h55, 64'h55, 64'h11, 2, 3'd0);
        add(0, 3'd2, 64'h00, 64'h11, 64'h00, 1, 3'd0);
        add(0, 3'd2, 64'h00, 64'h00, 64'h00, 0, 3'd0);
        add(1, 3'd2, 64'h00, 64'h00, 64'h00, 0, 3'd2);
        add(1, 3'd1, 64'h07, 64'h07, 64'h00, 1, 3'd0);
        add(0, 3'd4, 64'h01, 64'h07, 64'h00, 1, 3'd2);
        add(1, 3'd1, 64'h05, 64'h05, 64'h00, 1, 3'd0);
        add(0, 3'd5, 64'h00, 64'h05, 64'h05, 2, 3'd0);
        add(0, 3'd3, 64'h09, 64'h09, 64'h05, 2, 3'd0);
        add(0, 3'd6, 64'h00, 64'h09, 64'h05, 2, 3'd3);
        add(0, 3'd1, 64'h01, 64'h09, 64'h05, 2, 3'd3);
        add(1, 3'd3, 64'h03, 64'h00, 64'h00, 0, 3'd2);
        add(1, 3'd5, 64'h00, 64'h00, 64'h00, 0, 3'd2);
        add(1, 3'd7, 64'h00, 64'h00, 64'h00, 0, 3'd3);
        for (int i = 0; i < nv; i++) begin
            if (vecs[i].rst_before) do_reset();
            apply(vecs[i].op, vecs[i].din);
            chk_state($sformatf("vec%0d", i), vecs[i].e_top, vecs[i].e_next,
                      vecs[i].e_cnt, vecs[i].e_trap);
        end

        // Fill to full, overflow, then frozen POP
        do_reset();
        for (int i = 1; i <= 16; i++) apply(3'd1, 64'(i));
        chk_state("full", 64'd16, 64'd15, 16, 3'd0);
        apply(3'd1, 64'd99);
        chk_state("ovf", 64'd16, 64'd15, 16, 3'd1);
        apply(3'd2, 64'd0);
        chk_state("frozen", 64'd16, 64'd15, 16, 3'd1);

        // Drain a deep stack to check spill refill order
        do_reset();
        for (int i = 1; i <= 16; i++) apply(3'd1, 64'(i * 3));
        for (int i = 16; i >= 2; i--) begin
            apply(3'd2, 64'd0);
            chk_state("drain", 64'((i - 1) * 3), (i >= 3) ? 64'((i - 2) * 3) : 64'd0,
                      i - 1, 3'd0);
        end

        // High-water mark, then async reset between edges
        do_reset();
        for (int i = 0; i < 4; i++) apply(3'd1, 64'(i + 40));
        apply(3'd2, 64'd0);
        apply(3'd2, 64'd0);
        apply(3'd1, 64'd50);
`ifdef WASM_STACK_HWM_EN
        chk("hwm", 64'(bus.hwm), 64'd4);
`endif
        apply(3'd1, 64'd51);
        chk_state("pre_rst", 64'd51, 64'd50, 4, 3'd0);
        #3;
        reset = 1'b1;
        #1;
        chk_state("async_rst", 64'd0, 64'd0, 0, 3'd0);
`ifdef WASM_STACK_HWM_EN
        chk("hwm_rst", 64'(bus.hwm), 64'd0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Random ops against the reference model
        do_reset();
        for (int it = 0; it < 1500; it++) begin
            int          r;
            logic [2:0]  op;
            logic [63:0] din;
            r   = $urandom_range(0, 99);
            din = {$urandom, $urandom};
            if      (r < 40) op = 3'd1;
            else if (r < 60) op = 3'd2;
            else if (r < 70) op = 3'd3;
            else if (r < 80) op = 3'd4;
            else if (r < 92) op = 3'd5;
            else if (r < 93) op = 3'(6 + $urandom_range(0, 1));
            else             op = 3'd0;
            apply(op, din);
            model_op(op, din);
            chk_state("rand", m_top(), m_next(), mq.size(), mtrap);
`ifdef WASM_STACK_HWM_EN
            chk("rand.hwm", 64'(bus.hwm), 64'(mhwm));
`endif
            if (mtrap != 3'd0 && $urandom_range(0, 7) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
